// File: rtl/alu_pkg.sv
// Shared definitions for the Execute-stage ALU sharing controller:
// op codes, controller state encoding and condition-code reset values.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic CC_ZF_RST = 1'b1;
  localparam logic CC_SF_RST = 1'b0;
  localparam logic CC_OF_RST = 1'b0;

endpackage

// File: rtl/alu_core.sv
// Combinational W-bit ALU (add/sub/and/xor) with zero/sign/overflow flags.
// This is the single shared resource that both requesters time-multiplex.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [1:0]   fn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r,
  output logic         zf,
  output logic         sf,
  output logic         of
);

  always_comb begin
    r  = '0;
    of = 1'b0;
    case (fn)
      ALU_ADD: begin
        r  = b + a;
        of = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        r  = b - a;
        of = (a[W-1] != b[W-1]) && (r[W-1] != b[W-1]);
      end
      ALU_AND: r = b & a;
      ALU_XOR: r = b ^ a;
      default: r = '0;
    endcase
    zf = (r == '0);
    sf = r[W-1];
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one ALU between the execute datapath (port 0) and the
// address/stack unit (port 1); owns the CC register updated only by CC_OWNER.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int          W        = 64,
  parameter int unsigned CC_OWNER = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [3:0]     req_fn,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  input  logic [1:0]     req_set_cc,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_result,
  output logic           cc_zf,
  output logic           cc_sf,
  output logic           cc_of
);

  localparam logic CC_ID = 1'(CC_OWNER);

  state_t       state;
  logic         rr_ptr;
  logic [1:0]   lat_fn;
  logic [W-1:0] lat_a;
  logic [W-1:0] lat_b;
  logic         lat_set_cc;
  logic         lat_id;

  logic [1:0]   fn_arr [2];
  logic [W-1:0] a_arr  [2];
  logic [W-1:0] b_arr  [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign fn_arr[gi] = req_fn[gi*2 +: 2];
      assign a_arr[gi]  = req_a[gi*W +: W];
      assign b_arr[gi]  = req_b[gi*W +: W];
    end
  endgenerate

  // A lone requester always wins; rr_ptr only breaks ties.
  logic gnt_id;
  logic gnt_any;
  assign gnt_any = |req_valid;
  assign gnt_id  = (&req_valid) ? rr_ptr : (req_valid[1] & ~req_valid[0]);

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && gnt_any) req_ready[gnt_id] = 1'b1;
  end

  logic [W-1:0] alu_r;
  logic         alu_zf;
  logic         alu_sf;
  logic         alu_of;

  alu_core #(.W(W)) u_alu_core (
    .fn (lat_fn),
    .a  (lat_a),
    .b  (lat_b),
    .r  (alu_r),
    .zf (alu_zf),
    .sf (alu_sf),
    .of (alu_of)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      lat_fn     <= ALU_ADD;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_set_cc <= 1'b0;
      lat_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      cc_zf      <= CC_ZF_RST;
      cc_sf      <= CC_SF_RST;
      cc_of      <= CC_OF_RST;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            lat_fn     <= fn_arr[gnt_id];
            lat_a      <= a_arr[gnt_id];
            lat_b      <= b_arr[gnt_id];
            lat_set_cc <= req_set_cc[gnt_id];
            lat_id     <= gnt_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_r;
          rsp_id     <= lat_id;
          rsp_valid  <= 1'b1;
          if (lat_id == CC_ID && lat_set_cc) begin
            cc_zf <= alu_zf;
            cc_sf <= alu_sf;
            cc_of <= alu_of;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= ~lat_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
